// File: rtl/sc_backgtimer.sv
// sc_backgtimer: pacing timer for the background-lane state machine.
// Counts upcount pulses, flags expiry of the current lane period on T0,
// re-arms on the shift strobe, and shortens the period every
// SHIFTS_PER_LEVEL completed shifts until it reaches a floor.
module sc_backgtimer #(
  parameter int COUNT_WIDTH      = 24,
  parameter int PERIOD_INIT      = 1000000,
  parameter int PERIOD_STEP      = 100000,
  parameter int PERIOD_MIN       = 200000,
  parameter int SHIFTS_PER_LEVEL = 16,
  parameter int LEVEL_MAX        = 8
) (
  input  logic       SC_BACKGTIMER_CLOCK_50,
  input  logic       SC_BACKGTIMER_RESET_InHigh,
  input  logic       SC_BACKGTIMER_clear_InLow,
  input  logic       SC_BACKGTIMER_upcount_InLow,
  input  logic [1:0] SC_BACKGTIMER_shiftselection_In,
  output logic       SC_BACKGTIMER_T0_OutLow,
  output logic       SC_BACKGTIMER_T1_OutLow,
  output logic [3:0] SC_BACKGTIMER_level_Out
);

  // shift_cnt only has to reach SHIFTS_PER_LEVEL-1; keep at least one bit
  localparam int SC_W = (SHIFTS_PER_LEVEL > 1) ? $clog2(SHIFTS_PER_LEVEL) : 1;

  localparam logic [COUNT_WIDTH-1:0] P_INIT    = COUNT_WIDTH'(PERIOD_INIT);
  localparam logic [COUNT_WIDTH-1:0] P_STEP    = COUNT_WIDTH'(PERIOD_STEP);
  localparam logic [COUNT_WIDTH-1:0] P_MIN     = COUNT_WIDTH'(PERIOD_MIN);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
  // one extra bit so PERIOD_MIN + PERIOD_STEP can never wrap
  localparam logic [COUNT_WIDTH:0]   P_THRESH  = (COUNT_WIDTH+1)'(PERIOD_MIN) +
                                                 (COUNT_WIDTH+1)'(PERIOD_STEP);
  localparam logic [SC_W-1:0]        SHIFT_LAST = SC_W'(SHIFTS_PER_LEVEL - 1);
  localparam logic [SC_W-1:0]        SC_ONE     = SC_W'(1);
  localparam logic [3:0]             LEVEL_TOP  = 4'(LEVEL_MAX);
  localparam logic [3:0]             LVL_ONE    = 4'd1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EXPIRED = 2'd1,
    RELOAD  = 2'd2
  } state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] period;
  logic [SC_W-1:0]        shift_cnt;
  logic [3:0]             level;

  logic                   shift_strobe;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   at_level_max;

  assign shift_strobe = (SC_BACKGTIMER_shiftselection_In == 2'b10);
  assign count_inc    = count + CNT_ONE;
  assign at_level_max = (level == LEVEL_TOP);

  // Timer FSM: clear beats shift strobe, shift strobe beats upcount
  always_ff @(posedge SC_BACKGTIMER_CLOCK_50 or posedge SC_BACKGTIMER_RESET_InHigh) begin
    if (SC_BACKGTIMER_RESET_InHigh) begin
      state     <= RUN;
      count     <= '0;
      period    <= P_INIT;
      shift_cnt <= '0;
      level     <= '0;
    end else if (!SC_BACKGTIMER_clear_InLow) begin
      state     <= RUN;
      count     <= '0;
      period    <= P_INIT;
      shift_cnt <= '0;
      level     <= '0;
    end else begin
      case (state)
        RUN: begin
          if (shift_strobe) begin
            count <= '0;
          end else if (!SC_BACKGTIMER_upcount_InLow) begin
            count <= count_inc;
            if (count_inc == period) begin
              state <= EXPIRED;
            end
          end
        end
        EXPIRED: begin
          if (shift_strobe) begin
            state <= RELOAD;
          end
        end
        RELOAD: begin
          count <= '0;
          state <= RUN;
          if (shift_cnt == SHIFT_LAST) begin
            shift_cnt <= '0;
            if (!at_level_max) begin
              level <= level + LVL_ONE;
              if ({1'b0, period} >= P_THRESH) begin
                period <= period - P_STEP;
              end else begin
                period <= P_MIN;
              end
            end
          end else begin
            shift_cnt <= shift_cnt + SC_ONE;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign SC_BACKGTIMER_T0_OutLow = (state != EXPIRED);
  assign SC_BACKGTIMER_T1_OutLow = !at_level_max;
  assign SC_BACKGTIMER_level_Out = level;

endmodule

// File: tb/tb_sc_backgtimer.sv
// tb_sc_backgtimer: directed test of sc_backgtimer with small parameters
// (PERIOD_INIT=4, PERIOD_STEP=1, PERIOD_MIN=2, SHIFTS_PER_LEVEL=2, LEVEL_MAX=3).
module tb_sc_backgtimer;

  logic       clk;
  logic       rst;
  logic       clear_n;
  logic       upcount_n;
  logic [1:0] shift_sel;
  logic       t0_n;
  logic       t1_n;
  logic [3:0] level;

  int compared   = 0;
  int mismatched = 0;

  sc_backgtimer #(
    .COUNT_WIDTH     (24),
    .PERIOD_INIT     (4),
    .PERIOD_STEP     (1),
    .PERIOD_MIN      (2),
    .SHIFTS_PER_LEVEL(2),
    .LEVEL_MAX       (3)
  ) dut (
    .SC_BACKGTIMER_CLOCK_50         (clk),
    .SC_BACKGTIMER_RESET_InHigh     (rst),
    .SC_BACKGTIMER_clear_InLow      (clear_n),
    .SC_BACKGTIMER_upcount_InLow    (upcount_n),
    .SC_BACKGTIMER_shiftselection_In(shift_sel),
    .SC_BACKGTIMER_T0_OutLow        (t0_n),
    .SC_BACKGTIMER_T1_OutLow        (t1_n),
    .SC_BACKGTIMER_level_Out        (level)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck run still ends with a visible failure
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    clear_n   = 1'b1;
    upcount_n = 1'b1;
    shift_sel = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single-cycle upcount pulses with an idle cycle between them until T0
  // goes low right after a pulse edge; n = pulses used, 0 if it never did
  task automatic run_to_expiry(output int n);
    n = 0;
    for (int i = 1; i <= 16; i++) begin
      upcount_n = 1'b0;
      tick();
      upcount_n = 1'b1;
      if (t0_n === 1'b0) begin
        n = i;
        break;
      end
      tick();
    end
  endtask

  // One-cycle shift strobe; returns right after the sampling edge
  task automatic strobe_shift();
    shift_sel = 2'b10;
    tick();
    shift_sel = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_n = 1'b1;
    upcount_n = 1'b1;
    shift_sel = 2'b00;
    #1;
    compared++;
    if (t0_n !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_t0: got %b expected 1", t0_n);
    end
    compared++;
    if (t1_n !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_t1: got %b expected 1", t1_n);
    end
    compared++;
    if (level !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_level: got %0d expected 0", level);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic_expiry();
    int n;
    apply_reset();
    run_to_expiry(n);
    compared++;
    if (n !== 4) begin
      mismatched++;
      $display("[TB] FAIL basic_pulses: got %0d expected 4", n);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      upcount_n = 1'b0;
      tick();
      upcount_n = 1'b1;
    end
    compared++;
    if (t0_n !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_hold_t0: got %b expected 0", t0_n);
    end
  endtask

  task automatic test_rearm();
    int n;
    // continues from EXPIRED left by test_basic_expiry
    strobe_shift();
    compared++;
    if (t0_n !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rearm_t0_reload: got %b expected 1", t0_n);
    end
    tick();
    compared++;
    if (t0_n !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rearm_t0_run: got %b expected 1", t0_n);
    end
    compared++;
    if (level !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL rearm_level: got %0d expected 0", level);
    end
    run_to_expiry(n);
    compared++;
    if (n !== 4) begin
      mismatched++;
      $display("[TB] FAIL rearm_pulses: got %0d expected 4", n);
    end
  endtask

  task automatic test_level_progression();
    int n;
    int exp_pulses [8] = '{4, 4, 3, 3, 2, 2, 2, 2};
    int exp_level  [8] = '{0, 1, 1, 2, 2, 3, 3, 3};
    logic exp_t1   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      run_to_expiry(n);
      compared++;
      if (n !== exp_pulses[c]) begin
        mismatched++;
        $display("[TB] FAIL level_pulses[%0d]: got %0d expected %0d", c, n, exp_pulses[c]);
      end
      strobe_shift();
      compared++;
      if (t0_n !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL level_t0[%0d]: got %b expected 1", c, t0_n);
      end
      tick();
      compared++;
      if (level !== 4'(exp_level[c])) begin
        mismatched++;
        $display("[TB] FAIL level_value[%0d]: got %0d expected %0d", c, level, exp_level[c]);
      end
      compared++;
      if (t1_n !== exp_t1[c]) begin
        mismatched++;
        $display("[TB] FAIL level_t1[%0d]: got %b expected %b", c, t1_n, exp_t1[c]);
      end
    end
  endtask

  task automatic test_clear_priority();
    int n;
    int seq [4] = '{4, 4, 3, 3};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      run_to_expiry(n);
      strobe_shift();
      tick();
    end
    compared++;
    if (level !== 4'd2) begin
      mismatched++;
      $display("[TB] FAIL clear_setup_level: got %0d expected 2", level);
    end
    run_to_expiry(n);
    compared++;
    if (n !== 2) begin
      mismatched++;
      $display("[TB] FAIL clear_setup_pulses: got %0d expected 2", n);
    end
    clear_n   = 1'b0;
    shift_sel = 2'b10;
    upcount_n = 1'b0;
    tick();
    clear_n   = 1'b1;
    shift_sel = 2'b00;
    upcount_n = 1'b1;
    compared++;
    if (t0_n !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL clear_t0: got %b expected 1", t0_n);
    end
    compared++;
    if (level !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL clear_level: got %0d expected 0", level);
    end
    compared++;
    if (t1_n !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL clear_t1: got %b expected 1", t1_n);
    end
    tick();
    run_to_expiry(n);
    compared++;
    if (n !== seq[0]) begin
      mismatched++;
      $display("[TB] FAIL clear_pulses: got %0d expected %0d", n, seq[0]);
    end
  endtask

  task automatic test_early_shift();
    int n;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      upcount_n = 1'b0;
      tick();
      upcount_n = 1'b1;
      tick();
    end
    strobe_shift();
    compared++;
    if (t0_n !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL early_t0: got %b expected 1", t0_n);
    end
    run_to_expiry(n);
    compared++;
    if (n !== 4) begin
      mismatched++;
      $display("[TB] FAIL early_pulses: got %0d expected 4", n);
    end
    strobe_shift();
    tick();
    compared++;
    if (level !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL early_level_first: got %0d expected 0", level);
    end
    run_to_expiry(n);
    strobe_shift();
    tick();
    compared++;
    if (level !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL early_level_second: got %0d expected 1", level);
    end
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset();
    // climb to level 3 and sit in EXPIRED
    for (int c = 0; c < 6; c++) begin
      run_to_expiry(n);
      strobe_shift();
      tick();
    end
    run_to_expiry(n);
    compared++;
    if (t1_n !== 1'b0 || t0_n !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_setup: got t0=%b t1=%b expected t0=0 t1=0", t0_n, t1_n);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (t0_n !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL async_exp_t0: got %b expected 1", t0_n);
    end
    compared++;
    if (t1_n !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL async_exp_t1: got %b expected 1", t1_n);
    end
    compared++;
    if (level !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL async_exp_level: got %0d expected 0", level);
    end
    #2;
    rst = 1'b0;
    tick();
    // mid-count reset
    for (int i = 0; i < 2; i++) begin
      upcount_n = 1'b0;
      tick();
      upcount_n = 1'b1;
      tick();
    end
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    run_to_expiry(n);
    compared++;
    if (n !== 4) begin
      mismatched++;
      $display("[TB] FAIL async_count_pulses: got %0d expected 4", n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    apply_reset();
    upcount_n = 1'b0;
    tick();
    tick();
    tick();
    compared++;
    if (t0_n !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL held_up_t0_early: got %b expected 1", t0_n);
    end
    tick();
    upcount_n = 1'b1;
    compared++;
    if (t0_n !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL held_up_t0: got %b expected 0", t0_n);
    end
    shift_sel = 2'b10;
    tick();
    compared++;
    if (t0_n !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL held_shift_t0: got %b expected 1", t0_n);
    end
    tick();
    tick();
    shift_sel = 2'b00;
    run_to_expiry(n);
    compared++;
    if (n !== 4) begin
      mismatched++;
      $display("[TB] FAIL held_shift_pulses: got %0d expected 4", n);
    end
    compared++;
    if (level !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL held_shift_level: got %0d expected 0", level);
    end
  endtask

  initial begin
    test_reset();
    test_basic_expiry();
    test_rearm();
    test_level_progression();
    test_clear_priority();
    test_early_shift();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
